// File: rtl/main_memory_ctrl_pkg.sv
// Shared types and constants for the main-memory responder: bus widths,
// FSM state encoding, line-address type and the address-to-line helper.
package main_memory_ctrl_pkg;

    localparam int TAG_BITS         = 6;
    localparam int INDEX_BITS       = 8;
    localparam int BYTESELECT_BITS  = 2;
    localparam int ADDRESS_BITS     = TAG_BITS + INDEX_BITS + BYTESELECT_BITS;
    localparam int DATABUSWIDTH     = 32;
    localparam int MEM_LAT_BITS     = 4;
    localparam int MEMLINES_DEFAULT = 256;

    typedef enum logic [2:0] {
        MEM_IDLE,
        MEM_WRITE,
        MEM_FETCH,
        MEM_RESPOND,
        MEM_HOLD
    } mem_state_e;

    typedef logic [TAG_BITS+INDEX_BITS-1:0] lineaddr_t;

    // Byte-select bits are dropped; the {TAG, INDEX} line address wraps onto the array.
    function automatic int unsigned line_of(input logic [ADDRESS_BITS-1:0] a,
                                            input int unsigned lines);
        lineaddr_t la;
        la = lineaddr_t'(a >> BYTESELECT_BITS);
        return 32'(la) % lines;
    endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_line_array.sv
// Single-port line storage: synchronous write, registered read.
// Only the read register is reset; the stored lines keep their contents.
module mem_line_array #(
    parameter int LINES = 256,
    parameter int WIDTH = 32,
    parameter int IDX_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] lines [LINES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            lines[idx] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= lines[idx];
        end
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory responder: accepts line fill / write-back requests, models fixed
// latencies and pulses MemReady on completion. MEM_STATS_EN adds access counters.
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2,
    parameter int MEMLINES   = MEMLINES_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [DATABUSWIDTH-1:0] DataOut,
    output logic [DATABUSWIDTH-1:0] DataIn,
    output logic                    MemReady,
    output logic                    MemBusy
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]             RdCount,
    output logic [31:0]             WrCount
`endif
);

    localparam int IDX_W = (MEMLINES > 1) ? $clog2(MEMLINES) : 1;
    localparam logic [MEM_LAT_BITS-1:0] RD_LAT = MEM_LAT_BITS'(RD_LATENCY);
    localparam logic [MEM_LAT_BITS-1:0] WR_LAT = MEM_LAT_BITS'(WR_LATENCY);

    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
        $error("RD_LATENCY must be in 1..15");
    end
    if (WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_bad_wr_latency
        $error("WR_LATENCY must be in 1..15");
    end

    mem_state_e              state, state_d;
    logic [MEM_LAT_BITS-1:0] cnt, cnt_d;
    logic                    rd_q, wr_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATABUSWIDTH-1:0] data_q;
    logic                    we, re;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= MEM_IDLE;
            cnt    <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (state == MEM_IDLE && (READ || WRITE)) begin
                rd_q   <= READ;
                wr_q   <= WRITE;
                idx_q  <= IDX_W'(line_of(address, MEMLINES));
                data_q <= DataOut;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we      = 1'b0;
        re      = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (WRITE) begin
                    state_d = MEM_WRITE;
                    cnt_d   = WR_LAT;
                end else if (READ) begin
                    state_d = MEM_FETCH;
                    cnt_d   = RD_LAT;
                end
            end
            MEM_WRITE: begin
                cnt_d = cnt - 1'b1;
                if (cnt == 4'd1) begin
                    we = 1'b1;
                    // A combined request reads after the write so it sees the new line.
                    if (rd_q) begin
                        state_d = MEM_FETCH;
                        cnt_d   = RD_LAT;
                    end else begin
                        state_d = MEM_RESPOND;
                    end
                end
            end
            MEM_FETCH: begin
                cnt_d = cnt - 1'b1;
                if (cnt == 4'd1) begin
                    re      = 1'b1;
                    state_d = MEM_RESPOND;
                end
            end
            MEM_RESPOND: state_d = MEM_HOLD;
            MEM_HOLD:    state_d = MEM_IDLE;
            default:     state_d = MEM_IDLE;
        endcase
    end

    assign MemReady = (state == MEM_RESPOND);
    assign MemBusy  = (state == MEM_WRITE) || (state == MEM_FETCH) || (state == MEM_RESPOND);

    mem_line_array #(
        .LINES (MEMLINES),
        .WIDTH (DATABUSWIDTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .wr_en (we && !reset),
        .rd_en (re && !reset),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (DataIn)
    );

`ifdef MEM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            RdCount <= '0;
            WrCount <= '0;
        end else if (state == MEM_RESPOND) begin
            if (rd_q && RdCount != 32'hFFFF_FFFF) begin
                RdCount <= RdCount + 32'd1;
            end
            if (wr_q && WrCount != 32'hFFFF_FFFF) begin
                WrCount <= WrCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_main_memory_ctrl;

    localparam int RL = 4;
    localparam int WL = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = '0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [31:0] DataOut = '0;
    logic [31:0] DataIn;
    logic        MemReady;
    logic        MemBusy;
`ifdef MEM_STATS_EN
    logic [31:0] RdCount;
    logic [31:0] WrCount;
`endif

    main_memory_ctrl #(.RD_LATENCY(RL), .WR_LATENCY(WL), .MEMLINES(256)) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .READ     (READ),
        .WRITE    (WRITE),
        .DataOut  (DataOut),
        .DataIn   (DataIn),
        .MemReady (MemReady),
        .MemBusy  (MemBusy)
`ifdef MEM_STATS_EN
        ,
        .RdCount  (RdCount),
        .WrCount  (WrCount)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, cyc);
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    int          cyc = 0;
    int          idle_from = 0;
    bit          act = 0;
    int          rdy_edge = 0;
    bit          t_r, t_w;
    int          t_line;
    logic [31:0] t_data;
    logic [31:0] mref [256];
    logic [31:0] m_data = '0;
    bit          m_ready = 0;
    bit          m_busy = 0;
    logic [31:0] m_rd = '0;
    logic [31:0] m_wr = '0;
    bit          chk_en = 0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            act       = 0;
            m_data    = '0;
            m_rd      = '0;
            m_wr      = '0;
            idle_from = cyc + 1;
        end else begin
            if (act && cyc == rdy_edge) begin
                if (t_w) mref[t_line] = t_data;
                if (t_r) m_data = mref[t_line];
            end
            if (act && cyc == rdy_edge + 1) begin
                act = 0;
                if (t_r && m_rd != 32'hFFFF_FFFF) m_rd++;
                if (t_w && m_wr != 32'hFFFF_FFFF) m_wr++;
            end
            if (!act && cyc >= idle_from && (READ === 1'b1 || WRITE === 1'b1)) begin
                act       = 1;
                t_r       = (READ === 1'b1);
                t_w       = (WRITE === 1'b1);
                t_line    = int'(address >> 2) % 256;
                t_data    = DataOut;
                rdy_edge  = cyc + (t_w ? WL : 0) + (t_r ? RL : 0);
                idle_from = rdy_edge + 3;
            end
        end
        m_ready = act && (cyc == rdy_edge);
        m_busy  = act;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_ready", {31'b0, MemReady}, {31'b0, m_ready});
            check("mem_busy", {31'b0, MemBusy}, {31'b0, m_busy});
            check("data_in", DataIn, m_data);
`ifdef MEM_STATS_EN
            check("rd_count", RdCount, m_rd);
            check("wr_count", WrCount, m_wr);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] mk_addr(input int line, input int tag);
        return 16'((tag << 10) | (line << 2) | 1);
    endfunction

    // Called just after a negedge; returns cycles from acceptance to MemReady.
    task automatic run_txn(input bit r, input bit w, input logic [15:0] a,
                           input logic [31:0] d, output int lat);
        READ = r; WRITE = w; address = a; DataOut = d;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (MemReady === 1'b1) begin
                lat = i;
                break;
            end
        end
        READ = 1'b0; WRITE = 1'b0;
        if (lat < 0) begin
            n_chk++;
            $display("FAIL ready_timeout: got none expected MemReady within 40 cycles");
        end
    endtask

    task automatic gap();
        @(negedge clock);
        @(negedge clock);
    endtask

    int lat, pulses, first, second;

    initial begin
        repeat (3) @(negedge clock);
        chk_en = 1;
        check("reset_data_in", DataIn, 32'h0);
        check("reset_ready", {31'b0, MemReady}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // write then aliased read of line 0x12
        run_txn(0, 1, mk_addr(8'h12, 0), 32'hA5A5_A5A5, lat);
        check("wr_latency", lat, 32'd2);
        gap();
        run_txn(1, 0, mk_addr(8'h12, 3), 32'h0, lat);
        check("rd_latency", lat, 32'd4);
        check("rd_data_12", DataIn, 32'hA5A5_A5A5);
        gap();

        // combined request on line 0x30
        run_txn(1, 1, mk_addr(8'h30, 1), 32'h1234_1234, lat);
        check("comb_latency", lat, 32'd6);
        check("comb_data", DataIn, 32'h1234_1234);
        gap();

        // prior values for lines 0x05 and 0x40
        run_txn(0, 1, mk_addr(8'h05, 0), 32'h0505_0505, lat);
        gap();
        run_txn(0, 1, mk_addr(8'h40, 0), 32'h4040_4040, lat);
        gap();

        // write request presented while a fetch is in flight is ignored
        READ = 1'b1; address = mk_addr(8'h30, 0);
        @(negedge clock);
        READ = 1'b0; WRITE = 1'b1; address = mk_addr(8'h05, 0); DataOut = 32'hDEAD_BEEF;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (MemReady === 1'b1) begin
                pulses++;
                check("busy_rd_data", DataIn, 32'h1234_1234);
                WRITE = 1'b0;
            end
        end
        WRITE = 1'b0;
        check("busy_pulses", pulses, 32'd1);
        run_txn(1, 0, mk_addr(8'h05, 0), 32'h0, lat);
        check("line05_kept", DataIn, 32'h0505_0505);
        gap();

        // read held high across MemReady: re-accepted only after HOLD
        READ = 1'b1; address = mk_addr(8'h12, 0);
        first = -1; second = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (MemReady === 1'b1) begin
                if (first < 0) first = i;
                else begin
                    second = i;
                    READ = 1'b0;
                    break;
                end
            end
        end
        READ = 1'b0;
        check("held_first", first, 32'd4);
        check("held_gap", second - first, 32'd7);
        gap();

        // reset one cycle after a write to line 0x40 is accepted
        WRITE = 1'b1; address = mk_addr(8'h40, 0); DataOut = 32'hFFFF_0000;
        @(negedge clock);
        WRITE = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (MemReady === 1'b1) pulses++;
        end
        check("abort_pulses", pulses, 32'd0);
        check("abort_data_in", DataIn, 32'h0);
        check("abort_busy", {31'b0, MemBusy}, 32'h0);

        // three reads and two writes since that reset
        run_txn(1, 0, mk_addr(8'h40, 0), 32'h0, lat);
        check("line40_kept", DataIn, 32'h4040_4040);
        gap();
        run_txn(1, 0, mk_addr(8'h12, 2), 32'h0, lat);
        check("rd_data_12b", DataIn, 32'hA5A5_A5A5);
        gap();
        run_txn(0, 1, mk_addr(8'h12, 0), 32'h7777_7777, lat);
        gap();
        run_txn(0, 1, mk_addr(8'h30, 0), 32'h3030_3030, lat);
        gap();
        run_txn(1, 0, mk_addr(8'h30, 0), 32'h0, lat);
        check("rd_data_30", DataIn, 32'h3030_3030);
        gap();
`ifdef MEM_STATS_EN
        check("stats_rd", RdCount, 32'd3);
        check("stats_wr", WrCount, 32'd2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("stats_rd_clr", RdCount, 32'd0);
        check("stats_wr_clr", WrCount, 32'd0);
`endif
        repeat (2) @(negedge clock);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
